// File: rtl/pcm_fifo_player.sv
// PCM playback: pops one sample per sample period from the FIFO and drives it out as PWM.
// Read latency: fifo_rd one cycle after the tick, new sample visible three cycles after it.
// Optional build macro PCM_PLAYER_MUTE_ON_UNDERRUN_EN: an empty FIFO at a tick forces midscale.
module pcm_fifo_player #(
   parameter int dbits      = 8,
   parameter int sample_div = 2268,
   parameter int divw       = 12
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             play,
   input  logic             fifo_empty,
   input  logic [dbits-1:0] fifo_dout,
   output logic             fifo_rd,
   output logic             pwm_out,
   output logic [dbits-1:0] sample,
   output logic             underrun,
   input  logic             underrun_clr,
   output logic             busy
);

   localparam logic [divw-1:0]  DIV_LAST = divw'(sample_div - 1);
   localparam logic [dbits-1:0] MIDSCALE = {1'b1, {(dbits-1){1'b0}}};
   localparam logic [dbits-1:0] PWM_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE
   } state_t;

   state_t           state_q;
   logic             rd_q;
   logic             busy_q;
   logic             underrun_q;
   logic [dbits-1:0] sample_q;

   logic [divw-1:0]  div_q,     div_d;
   logic [dbits-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [dbits-1:0] duty_q,    duty_d;
   logic             pwm_q,     pwm_d;
   logic             tick;
   logic             underrun_set;

   // Sample-rate divider: parked at zero while stopped so restart is phase-deterministic.
   always_comb begin
      div_d = '0;
      tick  = 1'b0;
      if (play) begin
         if (div_q == DIV_LAST) begin
            tick = 1'b1;
         end else begin
            div_d = div_q + divw'(1);
         end
      end
   end

   // Duty is latched only at the period boundary so a running period is never disturbed.
   always_comb begin
      pwm_cnt_d = play ? pwm_cnt_q + dbits'(1) : '0;
      duty_d    = (pwm_cnt_q == PWM_LAST) ? sample_q : duty_q;
      pwm_d     = play & (pwm_cnt_q < duty_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         div_q     <= '0;
         pwm_cnt_q <= '0;
         duty_q    <= MIDSCALE;
         pwm_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
         pwm_q     <= pwm_d;
      end
   end

   assign underrun_set = (state_q == S_IDLE) && tick && fifo_empty;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         sample_q   <= MIDSCALE;
      end else begin
         rd_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (tick && !fifo_empty) begin
                  state_q <= S_READ;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
`ifdef PCM_PLAYER_MUTE_ON_UNDERRUN_EN
               else if (underrun_set) begin
                  sample_q <= MIDSCALE;
               end
`endif
            end
            S_READ: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               // FIFO data is registered, so it is valid the cycle after the strobe.
               sample_q <= fifo_dout;
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase

         if (underrun_set) begin
            underrun_q <= 1'b1;
         end else if (underrun_clr) begin
            underrun_q <= 1'b0;
         end
      end
   end

   assign fifo_rd  = rd_q;
   assign busy     = busy_q;
   assign underrun = underrun_q;
   assign sample   = sample_q;
   assign pwm_out  = pwm_q;

endmodule
